// File: rtl/mul16_seq.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier that borrows the ALU's shared adder.
// It runs one add per cycle for WIDTH cycles, then pulses done with the 2*WIDTH-bit product.
module mul16_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a16,
  input  logic [WIDTH-1:0]   b16,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod32,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] shifted;

  // Adder drive stays in its own process so the external adder path never loops back into one block.
  assign add_a   = (state_q == RUN) ? acc_hi_q : '0;
  assign add_b   = (state_q == RUN && acc_lo_q[0]) ? mcand_q : '0;
  assign add_cin = 1'b0;

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign prod32  = prod_q;

  // WIDTH+1-bit sum (carry included) shifted right into the accumulator pair.
  assign shifted = {add_cout, add_sum, acc_lo_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every _d starts as its _q, so no branch leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a16;
          acc_lo_d = b16;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        {acc_hi_d, acc_lo_d} = shifted;
        cnt_d                = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          prod_d  = shifted;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values in parallel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq: a vector table of hand-computed products plus
// hand-written sequences for reset mid-run, reset in DONE and held start.
module tb_mul16_seq;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a16, b16;
  logic               busy, done;
  logic [2*WIDTH-1:0] prod32;
  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  logic               add_cin, add_cout;
  logic [WIDTH:0]     add_full;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_prod = 32'h0;

  always #5 clk = ~clk;

  // Stand-in for the shared adder16 sitting beside the sequencer.
  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign add_sum  = add_full[WIDTH-1:0];
  assign add_cout = add_full[WIDTH];

  mul16_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a16      (a16),
    .b16      (b16),
    .busy     (busy),
    .done     (done),
    .prod32   (prod32),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    int          disturb;
    bit          zero;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                              input int disturb, input bit zero, input string name);
    vec_t v;
    v.a = a; v.b = b; v.exp = exp; v.disturb = disturb; v.zero = zero; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One full multiply: start at a negedge, then watch every cycle until well past done.
  task automatic run_vec(input vec_t v);
    int done_at  = 0;
    int done_cnt = 0;
    bit addb_nz  = 0;
    bit cin_nz   = 0;
    @(negedge clk);
    start = 1'b1; a16 = v.a; b16 = v.b;
    for (int n = 1; n <= LAT + 5; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check({v.name, "/busy_after_start"}, {31'b0, busy}, 32'h1);
        a16 = 16'($urandom); b16 = 16'($urandom);
      end
      if (n == 8) check({v.name, "/prod_hold_in_run"}, prod32, last_prod);
      if (busy && !done && add_b != '0) addb_nz = 1'b1;
      if (add_cin) cin_nz = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = n;
          check({v.name, "/prod"}, prod32, v.exp);
        end
      end
      if (done_at != 0 && n == done_at + 1) begin
        check({v.name, "/busy_low_after_done"}, {31'b0, busy}, 32'h0);
        check({v.name, "/prod_holds_in_idle"}, prod32, v.exp);
      end
      start = (n == v.disturb);
      if (n == v.disturb) begin a16 = 16'hAAAA; b16 = 16'h5555; end
    end
    start = 1'b0;
    check({v.name, "/latency"}, done_at, LAT);
    check({v.name, "/done_pulses"}, done_cnt, 1);
    check({v.name, "/cin_zero"}, {31'b0, cin_nz}, 32'h0);
    if (v.zero) check({v.name, "/add_b_zero"}, {31'b0, addb_nz}, 32'h0);
    last_prod = v.exp;
  endtask

  vec_t vecs[7];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    int  d1, d2, dcnt;
    bit  idle_drive;

    vecs[0] = mk(16'h0003, 16'h0005, 32'h0000000F, 0, 0, "3x5");
    vecs[1] = mk(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 0, "ffffxffff");
    vecs[2] = mk(16'h0000, 16'hBEEF, 32'h00000000, 0, 1, "0xbeef");
    vecs[3] = mk(16'h1234, 16'h0000, 32'h00000000, 0, 1, "1234x0");
    vecs[4] = mk(16'h00FF, 16'h0101, 32'h0000FFFF, 5, 0, "ffx101_restart");
    vecs[5] = mk(16'h8000, 16'h8000, 32'h40000000, 0, 0, "8000x8000");
    vecs[6] = mk(16'hFFFF, 16'h0002, 32'h0001FFFE, 0, 0, "ffffx2");

    rst_n = 1'b0; start = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("rst/busy",    {31'b0, busy},    32'h0);
    check("rst/done",    {31'b0, done},    32'h0);
    check("rst/prod",    prod32,           32'h0);
    check("rst/add_a",   {16'b0, add_a},   32'h0);
    check("rst/add_b",   {16'b0, add_b},   32'h0);
    check("rst/add_cin", {31'b0, add_cin}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset in the middle of RUN must clear everything without a clock edge.
    @(negedge clk);
    start = 1'b1; a16 = 16'h1234; b16 = 16'h5678;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrun/busy_before", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrun/busy",  {31'b0, busy},  32'h0);
    check("midrun/done",  {31'b0, done},  32'h0);
    check("midrun/prod",  prod32,         32'h0);
    check("midrun/add_a", {16'b0, add_a}, 32'h0);
    check("midrun/add_b", {16'b0, add_b}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_prod = 32'h0;
    run_vec(mk(16'h1234, 16'h5678, 32'h06260060, 0, 0, "1234x5678"));

    // Reset while done is high drops done asynchronously.
    @(negedge clk);
    start = 1'b1; a16 = 16'h0002; b16 = 16'h0003;
    seen = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin seen = 1; break; end
    end
    check("rstdone/saw_done", seen, 1);
    rst_n = 1'b0;
    #1;
    check("rstdone/done", {31'b0, done}, 32'h0);
    check("rstdone/busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // start held high: a new multiply every WIDTH+2 cycles.
    d1 = 0; d2 = 0; dcnt = 0; idle_drive = 0;
    start = 1'b1; a16 = 16'h0002; b16 = 16'h0003;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if ((!busy || done) && (add_a != '0 || add_b != '0)) idle_drive = 1'b1;
      if (done) begin
        dcnt++;
        if (dcnt == 1) d1 = n;
        if (dcnt == 2) d2 = n;
        check($sformatf("hold/prod_at_%0d", n), prod32, 32'h00000006);
      end
    end
    start = 1'b0;
    check("hold/done_count",  dcnt, 2);
    check("hold/first_done",  d1,   LAT);
    check("hold/second_done", d2,   2 * LAT + 1);
    check("hold/adder_idle",  {31'b0, idle_drive}, 32'h0);
    seen = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!busy) begin seen = 1; break; end
    end
    check("hold/drains_to_idle", seen, 1);
    check("hold/final_prod", prod32, 32'h00000006);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Unsigned 16x16 -> 32-bit shift-and-add multiplier sequencer for the ALU.
- Owns no adder of its own. It drives the operand and carry-in pins of the shared adder16 instance and consumes that adder's sum and carry-out.
- Issues one add per cycle over WIDTH cycles, then presents the 32-bit product.
- Sits beside the adder in cpu/alu and is started by the ALU control on a MUL opcode.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits; iteration count is WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a multiply; sampled only in IDLE.
a16  input  WIDTH  multiplicand; captured on accepted start.
b16  input  WIDTH  multiplier; captured on accepted start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; product valid.
prod32  output  2*WIDTH  product register; holds until the next accepted start.
add_a  output  WIDTH  to shared adder operand A.
add_b  output  WIDTH  to shared adder operand B.
add_cin  output  1  to shared adder carry-in; constant 0.
add_sum  input  WIDTH  from shared adder sum.
add_cout  input  1  from shared adder final carry-out.

Behaviour:
- Single clock. rst_n is asynchronous and active-low; it is released synchronously by the reset block upstream.
- States: IDLE, RUN, DONE.
- Internal registers: acc_hi[WIDTH-1:0], acc_lo[WIDTH-1:0] (holds the multiplier, shifted out LSB-first), mcand[WIDTH-1:0], cnt (ceil(log2 WIDTH) bits).
- Reset (asynchronous, any state):
  - state=IDLE; acc_hi, acc_lo, mcand, cnt, prod32 = 0.
  - busy=0, done=0.
  - add_a=0, add_b=0, add_cin=0.
- IDLE:
  - start=1 at a rising edge: mcand<=a16, acc_lo<=b16, acc_hi<=0, cnt<=0, state<=RUN.
  - start=0: stay in IDLE; all registers hold.
- RUN, combinational adder drive:
  - add_a = acc_hi.
  - add_b = acc_lo[0] ? mcand : 0.
  - add_cin = 0.
- RUN, each edge:
  - {acc_hi, acc_lo} <= {add_cout, add_sum, acc_lo[WIDTH-1:1]}, i.e. the WIDTH+1-bit sum is shifted right into the accumulator.
  - cnt <= cnt+1.
  - If cnt==WIDTH-1: prod32 <= {add_cout, add_sum, acc_lo[WIDTH-1:1]} and state<=DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: state<=IDLE.
  - add_a=0, add_b=0.
- Outside RUN, add_a=0, add_b=0 and add_cin=0, so the shared adder is free for other ALU ops.
- busy = (state != IDLE).
- Start handling:
  - start is ignored in RUN and DONE; it is not queued.
  - Earliest back-to-back start is the first IDLE cycle after DONE.
- Latency:
  - Accepted start at edge E0; iterations at edges E1..E_WIDTH.
  - done=1 and prod32 valid in the cycle after E_WIDTH, which is WIDTH+1 edges after acceptance (17 for WIDTH=16).
- Operand capture: a16 and b16 may change freely after the accepting edge without affecting the result.
- prod32 holding:
  - prod32 updates only on the final iteration edge.
  - It holds through DONE, IDLE and the next RUN until that run completes.
- Arithmetic:
  - Unsigned only.
  - The adder carry-out must be captured every iteration; dropping it corrupts products with bit 2*WIDTH-1 set.
  - acc_hi never exceeds WIDTH bits after shifting.
- Boundary behaviour:
  - Zero operand gives product 0, still in the full WIDTH cycles; there is no early termination.
  - Reset mid-RUN aborts immediately, with no done pulse; prod32 clears to 0.
  - Reset during DONE drops done asynchronously.
  - start held high continuously causes a new multiply every WIDTH+2 cycles: a start is accepted at each IDLE cycle.
- Adder path: the shared adder16 path is combinational, and the iteration must close timing in one clk period through add_a/add_b -> adder16 -> add_sum/add_cout -> registers.

Test Plan:
1. Reset, then start with a16=0x0003, b16=0x0005 -> busy high next cycle; done pulses exactly 17 cycles after the start edge; prod32=0x0000000F; busy low the following cycle.
2. a16=0xFFFF, b16=0xFFFF -> prod32=0xFFFE0001. This checks add_cout capture on every iteration.
3. a16=0x0000, b16=0xBEEF, then a16=0x1234, b16=0x0000 -> both give prod32=0, each with a full 17-cycle latency; add_b stays 0 throughout RUN.
4. Start with 0x00FF x 0x0101; pulse start again and change a16/b16 at cycle 5 of RUN -> second start ignored; prod32=0x0000FFFF; only one done pulse.
5. Start 0x1234 x 0x5678, then assert rst_n=0 at RUN cycle 8 -> busy, done, prod32 and add_a/add_b go 0 without waiting for a clock edge. After release, the next start 0x1234 x 0x5678 gives 0x06260060.
6. Hold start=1 for 40 cycles with a16=0x0002, b16=0x0003 -> done pulses at start+17 and start+35; prod32=0x00000006 each time; add_a/add_b=0 in IDLE and DONE cycles.
